// File: rtl/usr_pkg.sv
// Shared types for the universal shift register: operation codes and
// burst-engine FSM states.
package usr_pkg;

    // Operation codes; the encoding is visible on the mode input.
    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_SHR  = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_ROR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_LOAD = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } usr_mode_e;

    // Burst engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } usr_state_e;

    // LOAD and CLR always execute exactly once, whatever count says.
    function automatic logic mode_is_single(input usr_mode_e m);
        return (m == MODE_LOAD) || (m == MODE_CLR);
    endfunction

endpackage

// File: rtl/usr_step.sv
// One operation step of the universal shift register (purely combinational).
// Ports:
//   q_i       current register contents
//   si_i      serial input bit
//   mode_i    operation code
//   pdin_i    captured parallel load data
//   q_nxt_o   register contents after the operation
//   so_nxt_o  new serial-out value (meaningful when so_upd_o is high)
//   so_upd_o  high when the operation changes so
module usr_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             si_i,
    input  usr_mode_e        mode_i,
    input  logic [WIDTH-1:0] pdin_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic             so_nxt_o,
    output logic             so_upd_o
);

    // Select the result of the requested operation.
    always_comb begin
        q_nxt_o  = q_i;
        so_nxt_o = 1'b0;
        so_upd_o = 1'b0;
        case (mode_i)
            MODE_HOLD: begin
                q_nxt_o = q_i;
            end
            MODE_SHR: begin
                q_nxt_o  = {si_i, q_i[WIDTH-1:1]};
                so_nxt_o = q_i[0];
                so_upd_o = 1'b1;
            end
            MODE_SHL: begin
                q_nxt_o  = {q_i[WIDTH-2:0], si_i};
                so_nxt_o = q_i[WIDTH-1];
                so_upd_o = 1'b1;
            end
            MODE_ROR: begin
                q_nxt_o  = {q_i[0], q_i[WIDTH-1:1]};
                so_nxt_o = q_i[0];
                so_upd_o = 1'b1;
            end
            MODE_ROL: begin
                q_nxt_o  = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
                so_nxt_o = q_i[WIDTH-1];
                so_upd_o = 1'b1;
            end
            MODE_LOAD: begin
                q_nxt_o = pdin_i;
            end
            MODE_ASR: begin
                // Sign bit is replicated into the vacated MSB.
                q_nxt_o  = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
                so_nxt_o = q_i[0];
                so_upd_o = 1'b1;
            end
            MODE_CLR: begin
                q_nxt_o  = {WIDTH{1'b0}};
                so_nxt_o = 1'b0;
                so_upd_o = 1'b1;
            end
            default: begin
                q_nxt_o = q_i;
            end
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with a burst engine: one start pulse runs
// 'count' operations of the captured mode, then pulses done.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   start  burst request, sampled only when idle
//   mode   operation code, captured with start
//   count  number of operations, captured with start
//   si     serial input, sampled on every operation edge
//   pdin   parallel load data, captured with start
//   q      register contents (registered)
//   so     last bit shifted/rotated out (registered)
//   busy   high while the burst runs
//   done   one-cycle completion pulse
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] count,
    input  logic             si,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam logic [CNT_W-1:0] REM_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] REM_ZERO = CNT_W'(0);

    usr_state_e       state_q, state_d;
    usr_mode_e        mode_q,  mode_d;
    logic [WIDTH-1:0] pdin_q,  pdin_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [WIDTH-1:0] q_q,     q_d;
    logic             so_q,    so_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [WIDTH-1:0] step_q_s;
    logic             step_so_s;
    logic             step_upd_s;

    usr_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .si_i     (si),
        .mode_i   (mode_q),
        .pdin_i   (pdin_q),
        .q_nxt_o  (step_q_s),
        .so_nxt_o (step_so_s),
        .so_upd_o (step_upd_s)
    );

    // Burst FSM next state, capture of the request and datapath update.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        pdin_d  = pdin_q;
        rem_d   = rem_q;
        q_d     = q_q;
        so_d    = so_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = usr_mode_e'(mode);
                    pdin_d = pdin;
                    if (mode_is_single(usr_mode_e'(mode))) begin
                        rem_d   = REM_ONE;
                        state_d = ST_RUN;
                    end else if (count == REM_ZERO) begin
                        // Empty burst: nothing to do, just acknowledge.
                        rem_d   = count;
                        state_d = ST_DONE;
                    end else begin
                        rem_d   = count;
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                q_d   = step_q_s;
                rem_d = rem_q - REM_ONE;
                if (step_upd_s) begin
                    so_d = step_so_s;
                end else begin
                    so_d = so_q;
                end
                if (rem_q == REM_ONE) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Status flags are registered copies of the state being entered.
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    // State, captured request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_HOLD;
            pdin_q  <= {WIDTH{1'b0}};
            rem_q   <= REM_ZERO;
            q_q     <= {WIDTH{1'b0}};
            so_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            pdin_q  <= pdin_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            so_q    <= so_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign q    = q_q;
    assign so   = so_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=6, CNT_W=4): directed
// scenarios with literal expectations plus randomized traffic, all compared
// every cycle against an arithmetic reference model.
module tb_univ_shift_reg;

    localparam int W  = 6;
    localparam int CW = 4;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          start;
    logic [2:0]    mode;
    logic [CW-1:0] count;
    logic          si;
    logic [W-1:0]  pdin;
    logic [W-1:0]  q;
    logic          so;
    logic          busy;
    logic          done;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state.
    logic [W-1:0] m_q    = '0;
    logic         m_so   = 1'b0;
    int           m_left = 0;
    logic         m_done = 1'b0;
    logic [2:0]   m_mode = 3'd0;
    logic [W-1:0] m_pd   = '0;

    univ_shift_reg #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mode  (mode),
        .count (count),
        .si    (si),
        .pdin  (pdin),
        .q     (q),
        .so    (so),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result of one operation as integer arithmetic; returns {so, q}.
    function automatic logic [W:0] op_res(input logic [2:0] md, input logic [W-1:0] qv,
                                          input logic sov, input logic siv, input logic [W-1:0] pd);
        int v, top, full, nv, ns, s;
        v = int'(qv); top = 1 << (W - 1); full = 1 << W; s = int'(siv);
        nv = v; ns = int'(sov);
        case (md)
            3'd1: begin nv = (v >> 1) + s * top;          ns = v % 2;   end
            3'd2: begin nv = (v * 2 + s) % full;          ns = v / top; end
            3'd3: begin nv = (v >> 1) + (v % 2) * top;    ns = v % 2;   end
            3'd4: begin nv = (v * 2) % full + v / top;    ns = v / top; end
            3'd5: begin nv = int'(pd);                                  end
            3'd6: begin nv = (v >> 1) + (v / top) * top;  ns = v % 2;   end
            3'd7: begin nv = 0;                           ns = 0;       end
            default: ;
        endcase
        return {ns[0], nv[W-1:0]};
    endfunction

    // Reference model: burst bookkeeping by remaining-operation count.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q <= '0; m_so <= 1'b0; m_left <= 0; m_done <= 1'b0; m_mode <= 3'd0; m_pd <= '0;
        end else if (m_left > 0) begin
            {m_so, m_q} <= op_res(m_mode, m_q, m_so, si, m_pd);
            m_left      <= m_left - 1;
            m_done      <= (m_left == 1);
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_mode <= mode;
            m_pd   <= pdin;
            if (mode == 3'd5 || mode == 3'd7) m_left <= 1;
            else if (count == '0)             m_done <= 1'b1;
            else                              m_left <= int'(count);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("q",    32'(q),    32'(m_q));
            check("so",   32'(so),   32'(m_so));
            check("busy", 32'(busy), 32'(m_left > 0));
            check("done", 32'(done), 32'(m_done));
        end
    end

    task automatic start_burst(input logic [2:0] m, input logic [CW-1:0] c, input logic [W-1:0] p);
        @(negedge clk);
        start = 1'b1; mode = m; count = c; pdin = p;
        @(negedge clk);
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        count = CW'($urandom_range(0, 15));
        pdin  = W'($urandom_range(0, 63));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40 && done !== 1'b1; i++) @(negedge clk);
        check("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        logic [W-1:0] stream;
        start = 1'b0; mode = 3'd0; count = '0; si = 1'b0; pdin = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_q", 32'(q), 32'd0);
        check("rst_so", 32'(so), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // LOAD ignores count, then SHR by 3 with si=0.
        start_burst(3'b101, 4'd7, 6'b101101);
        wait_done();
        check("load_q", 32'(q), 32'b101101);
        start_burst(3'b001, 4'd3, 6'd0);
        check("shr_busy0", 32'(busy), 32'd1);
        @(negedge clk);
        check("shr_q1", 32'(q), 32'b010110); check("shr_so1", 32'(so), 32'd1);
        @(negedge clk);
        check("shr_q2", 32'(q), 32'b001011); check("shr_so2", 32'(so), 32'd0);
        @(negedge clk);
        check("shr_q3", 32'(q), 32'b000101); check("shr_so3", 32'(so), 32'd1);
        check("shr_done", 32'(done), 32'd1); check("shr_busy3", 32'(busy), 32'd0);
        @(negedge clk);

        // Full rotation left, single rotation right.
        start_burst(3'b101, 4'd0, 6'b101101); wait_done();
        start_burst(3'b100, 4'd6, 6'd0);      wait_done();
        check("rol_q", 32'(q), 32'b101101); check("rol_so", 32'(so), 32'd1);
        start_burst(3'b011, 4'd1, 6'd0);      wait_done();
        check("ror_q", 32'(q), 32'b110110); check("ror_so", 32'(so), 32'd1);

        // Arithmetic shift keeps the sign.
        start_burst(3'b101, 4'd0, 6'b100100); wait_done();
        start_burst(3'b110, 4'd2, 6'd0);      wait_done();
        check("asr_q", 32'(q), 32'b111001); check("asr_so", 32'(so), 32'd0);

        // Serial-in pattern through SHL.
        start_burst(3'b101, 4'd0, 6'b000000); wait_done();
        stream = 6'b101100;
        start_burst(3'b010, 4'd6, 6'd0);
        for (int i = 0; i < W; i++) begin
            si = stream[W-1-i];
            @(negedge clk);
        end
        si = 1'b0;
        check("shl_q", 32'(q), 32'b101100); check("shl_so", 32'(so), 32'd0);
        wait_done();

        // Zero-length burst: immediate done, no busy, q unchanged.
        start_burst(3'b101, 4'd0, 6'b101101); wait_done();
        start_burst(3'b001, 4'd0, 6'd0);
        check("zero_done", 32'(done), 32'd1); check("zero_busy", 32'(busy), 32'd0);
        check("zero_q", 32'(q), 32'b101101);
        wait_done();

        // start during RUN is ignored.
        start_burst(3'b101, 4'd0, 6'b110011); wait_done();
        start_burst(3'b001, 4'd4, 6'd0);
        @(negedge clk);
        start = 1'b1; mode = 3'b111;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        check("ign_q", 32'(q), 32'b000011);

        // Asynchronous reset in the middle of a burst.
        start_burst(3'b101, 4'd0, 6'b111111); wait_done();
        start_burst(3'b100, 4'd10, 6'd0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'd0); check("arst_busy", 32'(busy), 32'd0);
        check("arst_so", 32'(so), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic, including starts while busy.
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            si    = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 3) == 0);
            mode  = 3'($urandom_range(0, 7));
            count = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15)) : CW'($urandom_range(0, 3));
            pdin  = W'($urandom_range(0, 63));
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
